// File: rtl/song_sequencer.sv
// Melody sequencer: steps a fixed 14-entry note table once per QUARTER_BEAT transition
// and drives the current note code, its index and an end-of-song pulse.
module song_sequencer #(
    parameter int unsigned SONG_LEN = 14,
    parameter int unsigned NOTE_W   = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              QUARTER_BEAT,
    input  logic              PLAY,
    input  logic              STOP,
    input  logic              LOOP,
    output logic [NOTE_W-1:0] NOTE,
    output logic              NOTE_VALID,
    output logic [3:0]        STEP,
    output logic              SONG_DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_PLAYING,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'(SONG_LEN - 1);

    state_t            state_q;
    logic              q1_q, q2_q, q3_q;
    logic [1:0]        holdoff_q, holdoff_d;
    logic              tick;
    logic              rem_q;
    logic [NOTE_W-1:0] note_q;
    logic              valid_q;
    logic [3:0]        step_q;
    logic              done_q;
    logic [3:0]        load_idx;
    logic [3:0]        load_entry;

    // Table entry packed as {two_tick_duration, note_code[2:0]}.
    function automatic logic [3:0] song_entry(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1:   song_entry = {1'b0, 3'd1};
            4'd2, 4'd3:   song_entry = {1'b0, 3'd5};
            4'd4, 4'd5:   song_entry = {1'b0, 3'd6};
            4'd6:         song_entry = {1'b1, 3'd5};
            4'd7, 4'd8:   song_entry = {1'b0, 3'd4};
            4'd9, 4'd10:  song_entry = {1'b0, 3'd3};
            4'd11, 4'd12: song_entry = {1'b0, 3'd2};
            4'd13:        song_entry = {1'b1, 3'd1};
            default:      song_entry = '0;
        endcase
    endfunction

    assign holdoff_d = (holdoff_q == 2'd3) ? holdoff_q : holdoff_q + 2'd1;
    assign tick      = (holdoff_q == 2'd3) & (q2_q ^ q3_q);

    // Entry to load on the next step; wraps to 0 from ARM and from the last entry.
    always_comb begin
        load_idx = '0;
        if (state_q == S_PLAYING && step_q < LAST_STEP) begin
            load_idx = step_q + 4'd1;
        end
        load_entry = song_entry(load_idx);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            q1_q      <= 1'b0;
            q2_q      <= 1'b0;
            q3_q      <= 1'b0;
            holdoff_q <= '0;
            rem_q     <= 1'b0;
            note_q    <= '0;
            valid_q   <= 1'b0;
            step_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            q1_q      <= QUARTER_BEAT;
            q2_q      <= q1_q;
            q3_q      <= q2_q;
            holdoff_q <= holdoff_d;
            done_q    <= 1'b0;
            if (STOP) begin
                state_q <= S_IDLE;
                rem_q   <= 1'b0;
                note_q  <= '0;
                valid_q <= 1'b0;
                step_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (PLAY) state_q <= S_ARM;
                    end
                    S_ARM, S_PLAYING: begin
                        if (tick) begin
                            if (state_q == S_PLAYING && rem_q) begin
                                rem_q <= 1'b0;
                            end else if (state_q == S_ARM || step_q < LAST_STEP || LOOP) begin
                                state_q <= S_PLAYING;
                                step_q  <= load_idx;
                                note_q  <= NOTE_W'(load_entry[2:0]);
                                rem_q   <= load_entry[3];
                                valid_q <= 1'b1;
                            end else begin
                                state_q <= S_DONE;
                                note_q  <= '0;
                                valid_q <= 1'b0;
                                step_q  <= '0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign NOTE       = note_q;
    assign NOTE_VALID = valid_q;
    assign STEP       = step_q;
    assign SONG_DONE  = done_q;

endmodule
